// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: instruction width, base opcodes, NOP
// encoding, reset PC and the fetch FSM state encoding.
package riscv_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HAVE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect input and the
// decoder-side valid/ready handshake with decoded fields.
interface ifetch_unit_if
  import riscv_pkg::*;
;
  logic              imem_req;
  logic [INST_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [INST_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] inst_pc;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              misalign;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
           opcode, funct3, funct7, misalign,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
           opcode, funct3, funct7, misalign,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ifetch_pc.sv
// Program counter: reset load, redirect (word-aligned target) and +4 advance.
module ifetch_pc
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              redirect,
  input  logic [INST_W-1:2] redirect_tgt,
  output logic [INST_W-1:0] pc
);

  // Redirect beats advance; the +4 wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_tgt, 2'b00};
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HAVE fetch FSM, a one-entry instruction
// buffer feeding the decoder, and the misaligned-redirect flag.
module ifetch_unit
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ifetch_unit_if.master bus
);

  fetch_state_e      state, state_nxt;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] inst_p1;
  logic [INST_W-1:0] inst_pc_p1;
  logic              misalign_p1;
  logic              capture;

  // A word is only kept when it is acked in REQ and not squashed by a redirect.
  assign capture = (state == REQ) && bus.imem_ack && !bus.redirect;

  ifetch_pc u_pc (
    .clk          (clk),
    .rst          (rst),
    .advance      (capture),
    .redirect     (bus.redirect),
    .redirect_tgt (bus.redirect_pc[INST_W-1:2]),
    .pc           (pc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: redirect always restarts fetch at the new PC.
  always_comb begin
    state_nxt = state;
    if (bus.redirect) begin
      state_nxt = REQ;
    end else begin
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     if (bus.imem_ack)   state_nxt = HAVE;
        HAVE:    if (bus.inst_ready) state_nxt = REQ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Instruction buffer: holds the word and its PC while the decoder stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_p1    <= NOP_INST;
      inst_pc_p1 <= RESET_PC;
    end else if (capture) begin
      inst_p1    <= bus.imem_rdata;
      inst_pc_p1 <= pc;
    end
  end

  // Misalign flag: one-cycle pulse after a redirect to a non-word address.
  always_ff @(posedge clk) begin
    if (rst) misalign_p1 <= 1'b0;
    else     misalign_p1 <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  end

  assign bus.imem_req   = (state == REQ);
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (state == HAVE);
  assign bus.inst       = inst_p1;
  assign bus.inst_pc    = inst_pc_p1;
  assign bus.opcode     = inst_p1[6:0];
  assign bus.funct3     = inst_p1[14:12];
  assign bus.funct7     = inst_p1[31:25];
  assign bus.misalign   = misalign_p1;

endmodule
